// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported, fixed-latency memory between the fetch port (I) and the data port (D).
// Data normally wins; a starvation streak forces a fetch grant, and a tag pipe routes each response home.
module mem_port_arbiter #(
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned MAX_STREAK = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] rdata,
   input  logic        mem_ready,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

   logic [3:0]         streak_r;
   logic               pick_d_s;
   logic [LATENCY-1:0] tag_valid_r;
   logic [LATENCY-1:0] tag_port_r;
   logic [LATENCY:0]   tag_valid_next_s;
   logic [LATENCY:0]   tag_port_next_s;

   // Winner selection, grants and command mux (same-cycle decision)
   always_comb begin
      pick_d_s  = d_req & ~(i_req & (streak_r == STREAK_MAX));
      mem_valid = (i_req | d_req) & mem_ready;
      d_gnt     = mem_valid & pick_d_s;
      i_gnt     = mem_valid & ~pick_d_s;
      if (pick_d_s) begin
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_wstrb = d_wstrb;
      end else begin
         mem_we    = 1'b0;
         mem_addr  = i_addr;
         mem_wdata = 32'd0;
         mem_wstrb = 4'd0;
      end
   end

   // Count consecutive D grants while I waits; any idle I cycle or I grant ends the streak
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak_r <= 4'd0;
      end else if (i_gnt || !i_req) begin
         streak_r <= 4'd0;
      end else if (d_gnt && (streak_r != STREAK_MAX)) begin
         streak_r <= streak_r + 4'd1;
      end else begin
         streak_r <= streak_r;
      end
   end

   assign tag_valid_next_s = {tag_valid_r, mem_valid};
   assign tag_port_next_s  = {tag_port_r, pick_d_s};

   // Tag pipe: one {valid, port} entry per memory latency stage; reset drops in-flight tags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid_r <= '0;
         tag_port_r  <= '0;
      end else begin
         tag_valid_r <= tag_valid_next_s[LATENCY-1:0];
         tag_port_r  <= tag_port_next_s[LATENCY-1:0];
      end
   end

   assign i_rvalid = tag_valid_r[LATENCY-1] & ~tag_port_r[LATENCY-1];
   assign d_rvalid = tag_valid_r[LATENCY-1] & tag_port_r[LATENCY-1];
   assign rdata    = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters share one stimulus stream: dut0 (LATENCY=2, MAX_STREAK=3) and dut1 (LATENCY=3, MAX_STREAK=1).
// Issued commands push expected responses; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

   localparam int LAT_A = 2;
   localparam int LAT_B = 3;

   typedef struct {
      logic        is_d;
      logic [31:0] at;
      logic [31:0] data;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, d_req, d_we, mem_ready;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_wstrb;
   logic [31:0] cyc = 32'd0;
   logic [31:0] mem_rdata;

   logic [1:0]  i_gnt, d_gnt, i_rvalid, d_rvalid, mem_valid, mem_we;
   logic [31:0] rdata [2];
   logic [31:0] mem_addr [2];
   logic [31:0] mem_wdata [2];
   logic [3:0]  mem_wstrb [2];

   resp_t q [2][$];
   int checks = 0;
   int errors = 0;

   assign mem_rdata = 32'hC0DE_0000 ^ cyc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   mem_port_arbiter #(.LATENCY(LAT_A), .MAX_STREAK(3)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .rdata(rdata[0]),
      .mem_ready(mem_ready), .mem_valid(mem_valid[0]), .mem_we(mem_we[0]),
      .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
      .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.LATENCY(LAT_B), .MAX_STREAK(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .rdata(rdata[1]),
      .mem_ready(mem_ready), .mem_valid(mem_valid[1]), .mem_we(mem_we[1]),
      .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
      .mem_rdata(mem_rdata)
   );

   task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, p, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; ea/eb are the hand-computed winners ("I", "D" or "-") for dut0/dut1
   task automatic step(input logic ir, input logic dr, input logic we, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws,
                       input logic rdy, input byte ea, input byte eb);
      byte         e;
      logic [31:0] lat;
      @(posedge clk);
      #1;
      i_req = ir; d_req = dr; d_we = we; i_addr = ia; d_addr = da;
      d_wdata = wd; d_wstrb = ws; mem_ready = rdy;
      #2;
      for (int p = 0; p < 2; p++) begin
         e   = (p == 0) ? ea : eb;
         lat = (p == 0) ? 32'(LAT_A) : 32'(LAT_B);
         chk("grant", p, {30'd0, i_gnt[p], d_gnt[p]}, (e == "I") ? 32'd2 : ((e == "D") ? 32'd1 : 32'd0));
         chk("mem_valid", p, {31'd0, mem_valid[p]}, {31'd0, e != "-"});
         if (e != "-") begin
            chk("mem_addr", p, mem_addr[p], (e == "D") ? da : ia);
            chk("mem_we", p, {31'd0, mem_we[p]}, {31'd0, (e == "D") & we});
            chk("mem_wdata", p, mem_wdata[p], (e == "D") ? wd : 32'd0);
            chk("mem_wstrb", p, {28'd0, mem_wstrb[p]}, {28'd0, (e == "D") ? ws : 4'd0});
            q[p].push_back('{is_d: (e == "D"), at: cyc + lat, data: 32'hC0DE_0000 ^ (cyc + lat)});
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b1, "-", "-");
   endtask

   task automatic cont(input byte ea, input byte eb);
      step(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0300, 32'd0, 4'd0, 1'b1, ea, eb);
   endtask

   // Response monitor: every rvalid must match the oldest outstanding expectation in port, cycle and data
   always @(negedge clk) begin
      resp_t r;
      if (rst_n) begin
         for (int p = 0; p < 2; p++) begin
            if ((q[p].size() > 0) && (q[p][0].at < cyc)) begin
               chk("missing_resp_cycle", p, cyc, q[p][0].at);
               void'(q[p].pop_front());
            end
            if (i_rvalid[p] | d_rvalid[p]) begin
               if (q[p].size() == 0) begin
                  chk("unexpected_resp", p, {30'd0, i_rvalid[p], d_rvalid[p]}, 32'd0);
               end else begin
                  r = q[p].pop_front();
                  chk("resp_port", p, {30'd0, i_rvalid[p], d_rvalid[p]}, r.is_d ? 32'd1 : 32'd2);
                  chk("resp_cycle", p, cyc, r.at);
                  chk("resp_rdata", p, rdata[p], r.data);
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1;
      i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0;
      #2;
      for (int p = 0; p < 2; p++) chk("reset_rvalid", p, {30'd0, i_rvalid[p], d_rvalid[p]}, 32'd0);
      i_req = 1'b1;
      #1;
      for (int p = 0; p < 2; p++) chk("reset_comb_grant", p, {30'd0, i_gnt[p], d_gnt[p]}, 32'd2);
      i_req = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Lone fetch, then a lone data write
      step(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'd0, 32'd0, 4'd0, 1'b1, "I", "I");
      idle(3);
      step(1'b0, 1'b1, 1'b1, 32'd0, 32'h0000_0040, 32'hDEAD_BEEF, 4'h3, 1'b1, "D", "D");
      idle(3);

      // Sustained contention: streak limit 3 vs strict alternation at limit 1
      cont("D", "D"); cont("D", "I"); cont("D", "D"); cont("I", "I");
      cont("D", "D"); cont("D", "I"); cont("D", "D"); cont("I", "I");
      cont("D", "D"); cont("D", "I");

      // Backpressure holds the streak; dut0 resumes at streak 2
      for (int k = 0; k < 3; k++)
         step(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0300, 32'd0, 4'd0, 1'b0, "-", "-");
      cont("D", "D"); cont("I", "I");

      // A cycle with i_req low clears the streak
      cont("D", "D");
      step(1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0304, 32'd0, 4'd0, 1'b1, "D", "D");
      cont("D", "D"); cont("D", "I"); cont("D", "D"); cont("I", "I");
      idle(4);

      // Async reset with tags in flight
      cont("D", "D"); cont("D", "I");
      @(posedge clk);
      #1 i_req = 1'b0; d_req = 1'b0;
      #1 rst_n = 1'b0;
      q[0].delete();
      q[1].delete();
      #1;
      for (int p = 0; p < 2; p++) chk("async_reset_rvalid", p, {30'd0, i_rvalid[p], d_rvalid[p]}, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      idle(4);
      cont("D", "D"); cont("D", "I"); cont("D", "D"); cont("I", "I");
      idle(6);

      for (int p = 0; p < 2; p++) chk("drain", p, q[p].size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
